// File: rtl/dot_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dot_scan_ctrl
// Brief    : Per-frame PacMan/dot collision scanner with score and level state.
// Revision : 1.0 - initial release
// ============================================================================
module dot_scan_ctrl #(
  parameter int NUM_DOTS   = 32,
  parameter int DOT_POINTS = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_tick,
  input  logic        level_restart,
  input  logic [9:0]  pX,
  input  logic [9:0]  pY,
  input  logic [9:0]  pS,
  output logic [4:0]  dot_idx,
  input  logic [9:0]  dot_x,
  input  logic [9:0]  dot_y,
  output logic [31:0] eaten,
  output logic [5:0]  dots_left,
  output logic [15:0] score,
  output logic        dot_pulse,
  output logic        scan_done,
  output logic        busy,
  output logic        level_clear,
  output logic        overrun
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_SCAN = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  localparam logic [4:0]  c_LAST = 5'(NUM_DOTS - 1);
  localparam logic [5:0]  c_FULL = 6'(NUM_DOTS);
  localparam logic [31:0] c_MASK = 32'((64'd1 << NUM_DOTS) - 64'd1);
  localparam logic [16:0] c_PTS  = 17'(DOT_POINTS);

  logic [1:0]  state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [9:0]  px_q, px_d;
  logic [9:0]  py_q, py_d;
  logic [9:0]  ps_q, ps_d;
  logic [31:0] eaten_q, eaten_d;
  logic [5:0]  left_q, left_d;
  logic [15:0] score_q, score_d;
  logic        clear_q, clear_d;
  logic        ovr_q, ovr_d;

  logic [10:0] w_dx, w_dy, w_rad;
  logic        w_hit, w_new_hit, w_start;
  logic [16:0] w_sum;

  // Differences are formed in 11 bits so that no coordinate pair can wrap.
  always_comb begin
    w_rad = {1'b0, ps_q};
    if (dot_x >= px_q) w_dx = {1'b0, dot_x} - {1'b0, px_q};
    else               w_dx = {1'b0, px_q} - {1'b0, dot_x};
    if (dot_y >= py_q) w_dy = {1'b0, dot_y} - {1'b0, py_q};
    else               w_dy = {1'b0, py_q} - {1'b0, dot_y};
    w_hit = (w_dx <= w_rad) && (w_dy <= w_rad);
  end

  assign w_start   = (state_q == c_IDLE) && frame_tick && !level_restart;
  assign w_new_hit = (state_q == c_SCAN) && w_hit && !eaten_q[idx_q] && !level_restart;
  assign w_sum     = {1'b0, score_q} + c_PTS;

  // State register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_q <= c_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (level_restart) begin
      state_d = c_IDLE;
    end else begin
      case (state_q)
        c_IDLE:  if (frame_tick) state_d = c_SCAN;
        c_SCAN:  if (idx_q == c_LAST) state_d = c_DONE;
        c_DONE:  state_d = c_IDLE;
        default: state_d = c_IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    busy      = (state_q == c_SCAN) || (state_q == c_DONE);
    scan_done = (state_q == c_DONE);
    dot_pulse = w_new_hit;
  end

  // Datapath next-state
  always_comb begin
    idx_d   = 5'd0;
    px_d    = px_q;
    py_d    = py_q;
    ps_d    = ps_q;
    eaten_d = eaten_q;
    left_d  = left_q;
    score_d = score_q;
    clear_d = clear_q;
    ovr_d   = ovr_q;

    if (level_restart) begin
      eaten_d = 32'd0;
      left_d  = c_FULL;
      clear_d = 1'b0;
      ovr_d   = 1'b0;
    end else begin
      if (w_start) begin
        px_d = pX;
        py_d = pY;
        ps_d = pS;
      end
      if ((state_q == c_SCAN) && (idx_q != c_LAST)) idx_d = idx_q + 5'd1;
      if (w_new_hit) begin
        eaten_d = (eaten_q | (32'd1 << idx_q)) & c_MASK;
        if (left_q != 6'd0) left_d = left_q - 6'd1;
        score_d = w_sum[16] ? 16'hFFFF : w_sum[15:0];
      end
      if ((state_q == c_DONE) && (left_q == 6'd0)) clear_d = 1'b1;
      if (frame_tick && (state_q != c_IDLE)) ovr_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      idx_q   <= 5'd0;
      px_q    <= 10'd0;
      py_q    <= 10'd0;
      ps_q    <= 10'd0;
      eaten_q <= 32'd0;
      left_q  <= c_FULL;
      score_q <= 16'd0;
      clear_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      px_q    <= px_d;
      py_q    <= py_d;
      ps_q    <= ps_d;
      eaten_q <= eaten_d;
      left_q  <= left_d;
      score_q <= score_d;
      clear_q <= clear_d;
      ovr_q   <= ovr_d;
    end
  end

  assign dot_idx     = idx_q;
  assign eaten       = eaten_q;
  assign dots_left   = left_q;
  assign score       = score_q;
  assign level_clear = clear_q;
  assign overrun     = ovr_q;

endmodule
`default_nettype wire
